// File: rtl/chain_pkg.sv
// Shared constants for the shift chain monitor.
// State encoding and default geometry.
package chain_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_SYNC  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/shift_chain_monitor.sv
// Receive-side checker for an a -> b -> c shift chain.
// Locks after a run of clean compares, then counts errors and c edges.
module shift_chain_monitor
  import chain_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_CYCLES = 4,
  parameter int ERR_LIMIT   = 8,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic [1:0]       state,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             fail
);

  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;

  logic [DEPTH:1]  refp;
  logic [FW-1:0]   fill_cnt;
  logic [FW-1:0]   fill_n;
  logic [MW-1:0]   match_cnt;
  logic [MW-1:0]   match_n;
  logic [1:0]      state_n;
  logic            c_d;
  logic            mismatch;
  logic            chk;
  logic            err_inc;
  logic            edge_inc;
  logic            fail_hit;

  assign mismatch = (b != refp[1]) | (c != refp[DEPTH]);
  assign chk      = (state == ST_CHECK) && !fail;
  assign err_inc  = chk && mismatch;
  assign edge_inc = chk && c && !c_d;
  assign fail_hit = err_inc && (err_cnt == CNT_W'(ERR_LIMIT - 1));

  // Failure outranks en; the state stays encoded as CHECK.
  always_comb begin
    state_n = state;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    if (fail || fail_hit) begin
      state_n = state;
    end else if (!en) begin
      state_n = ST_IDLE;
      fill_n  = '0;
      match_n = '0;
    end else begin
      unique case (1'b1)
        state == ST_IDLE: begin
          state_n = ST_FILL;
          fill_n  = '0;
        end
        state == ST_FILL: begin
          if (fill_cnt == FW'(DEPTH - 1)) begin
            state_n = ST_SYNC;
            fill_n  = '0;
          end else begin
            fill_n = fill_cnt + 1'b1;
          end
        end
        state == ST_SYNC: begin
          if (mismatch) begin
            match_n = '0;
          end else if (match_cnt == MW'(SYNC_CYCLES - 1)) begin
            state_n = ST_CHECK;
            match_n = '0;
          end else begin
            match_n = match_cnt + 1'b1;
          end
        end
        state == ST_CHECK: begin
          state_n = ST_CHECK;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      match_cnt <= '0;
      refp      <= '0;
      c_d       <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      c_d       <= c;
      err_pulse <= err_inc;
      locked    <= (state_n == ST_CHECK) && !fail && !fail_hit;
      if (fail_hit) begin
        fail <= 1'b1;
      end
      if (en) begin
        refp[1] <= a;
        for (int k = 2; k <= DEPTH; k++) begin
          refp[k] <= refp[k-1];
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .clr (1'b0),
    .q   (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_edge (
    .clk (clk),
    .rst (rst),
    .inc (edge_inc),
    .clr (1'b0),
    .q   (edge_cnt)
  );

endmodule

// File: tb/tb_shift_chain_monitor.sv
// Directed bench for shift_chain_monitor (DEPTH=2 and DEPTH=3).
// Ideal chain model with fault injection on b and c.
module tb_shift_chain_monitor;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst;
  logic en;
  logic [1:0] cmode;
  logic glb;

  logic a_q  = 1'b0;
  logic b_q  = 1'b0;
  logic c_q  = 1'b0;
  logic x_q  = 1'b0;
  logic c3_q = 1'b0;

  always @(posedge clk) begin
    a_q  <= ~a_q;
    b_q  <= a_q;
    c_q  <= b_q;
    x_q  <= b_q;
    c3_q <= x_q;
  end

  logic b2;
  logic c2;
  assign b2 = b_q ^ glb;
  assign c2 = (cmode == 2'd2) ? 1'b0 : (c_q ^ (cmode == 2'd1));

  logic [1:0]  s2, s3;
  logic        l2, l3, p2, p3, f2, f3;
  logic [15:0] e2, e3, g2, g3;

  shift_chain_monitor #(.DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .a(a_q), .b(b2), .c(c2),
    .state(s2), .locked(l2), .err_pulse(p2),
    .err_cnt(e2), .edge_cnt(g2), .fail(f2)
  );

  shift_chain_monitor #(.DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .a(a_q), .b(b_q), .c(c3_q),
    .state(s3), .locked(l3), .err_pulse(p3),
    .err_cnt(e3), .edge_cnt(g3), .fail(f3)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] cmode;
    logic       glb;
    int         n;
    logic [1:0] st;
    logic       lk;
    logic       pl;
    logic       fl;
    int         err;
    int         edg;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] cm,
                     input logic g, input int n, input logic [1:0] st,
                     input logic lk, input logic pl, input logic fl,
                     input int err, input int edg);
    vec_t v;
    v.rst = r; v.en = e; v.cmode = cm; v.glb = g; v.n = n;
    v.st = st; v.lk = lk; v.pl = pl; v.fl = fl;
    v.err = err; v.edg = edg;
    tv.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;
    bit hit;
    int n2;
    int n3;

    rst = 1'b1; en = 1'b0; cmode = 2'd0; glb = 1'b0;

    // startup, single c glitches, en drop, reset, SYNC glitch on b
    add(1,0,0,0,1,   0,0,0,0,0,0);
    add(0,0,0,0,1,   0,0,0,0,0,0);
    add(0,1,0,0,1,   1,0,0,0,0,0);
    add(0,1,0,0,1,   1,0,0,0,0,0);
    add(0,1,0,0,1,   2,0,0,0,0,0);
    add(0,1,0,0,3,   2,0,0,0,0,0);
    add(0,1,0,0,1,   3,1,0,0,0,0);
    add(0,1,0,0,100, 3,1,0,0,0,50);
    add(0,1,1,0,1,   3,1,1,0,1,-1);
    add(0,1,0,0,1,   3,1,0,0,1,-1);
    add(0,1,1,0,1,   3,1,1,0,2,-1);
    add(0,1,0,0,1,   3,1,0,0,2,-1);
    add(0,1,1,0,1,   3,1,1,0,3,-1);
    add(0,1,0,0,1,   3,1,0,0,3,-1);
    add(0,0,0,0,1,   0,0,0,0,3,-1);
    add(0,1,0,0,1,   1,0,0,0,3,-1);
    add(0,1,0,0,5,   2,0,0,0,3,-1);
    add(0,1,0,0,1,   3,1,0,0,3,-1);
    add(1,1,0,0,1,   0,0,0,0,0,0);
    add(0,1,0,0,1,   1,0,0,0,0,0);
    add(0,1,0,0,2,   2,0,0,0,0,0);
    add(0,1,0,0,3,   2,0,0,0,0,0);
    add(0,1,0,1,1,   2,0,0,0,0,0);
    add(0,1,0,0,3,   2,0,0,0,0,0);
    add(0,1,0,0,1,   3,1,0,0,0,0);

    foreach (tv[i]) begin
      rst = tv[i].rst; en = tv[i].en;
      cmode = tv[i].cmode; glb = tv[i].glb;
      repeat (tv[i].n) @(posedge clk);
      #1;
      chk($sformatf("row%0d.state", i), int'(s2), int'(tv[i].st));
      chk($sformatf("row%0d.locked", i), int'(l2), int'(tv[i].lk));
      chk($sformatf("row%0d.err_pulse", i), int'(p2), int'(tv[i].pl));
      chk($sformatf("row%0d.fail", i), int'(f2), int'(tv[i].fl));
      chk($sformatf("row%0d.err_cnt", i), int'(e2), tv[i].err);
      if (tv[i].edg >= 0)
        chk($sformatf("row%0d.edge_cnt", i), int'(g2), tv[i].edg);
    end
    rst = 1'b0; glb = 1'b0;

    // c stuck at 0: errors climb one at a time up to the limit
    cmode = 2'd2;
    prev = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      if (int'(e2) != prev) begin
        chk("stuck.step", int'(e2), prev + 1);
        chk("stuck.pulse", int'(p2), 1);
        chk("stuck.fail", int'(f2), (int'(e2) == 8) ? 1 : 0);
        chk("stuck.locked", int'(l2), (int'(e2) == 8) ? 0 : 1);
        if (int'(e2) >= 8) hit = 1'b1;
        prev = int'(e2);
      end
    end
    chk("stuck.reach8", int'(hit), 1);

    repeat (6) @(posedge clk);
    #1;
    chk("frz.err_cnt", int'(e2), 8);
    chk("frz.fail", int'(f2), 1);
    chk("frz.locked", int'(l2), 0);
    chk("frz.err_pulse", int'(p2), 0);
    chk("frz.state", int'(s2), 3);

    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("frz.en0.state", int'(s2), 3);
    chk("frz.en0.fail", int'(f2), 1);
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("frz.en1.fail", int'(f2), 1);
    chk("frz.en1.err_cnt", int'(e2), 8);
    chk("frz.en1.locked", int'(l2), 0);

    rst = 1'b1;
    @(posedge clk); #1;
    chk("frst.state", int'(s2), 0);
    chk("frst.fail", int'(f2), 0);
    chk("frst.err_cnt", int'(e2), 0);
    chk("frst.edge_cnt", int'(g2), 0);
    chk("frst.locked", int'(l2), 0);
    chk("frst.err_pulse", int'(p2), 0);
    rst = 1'b0;
    cmode = 2'd0;

    // lock latency for both depths, then reset the DEPTH=3 unit in CHECK
    n2 = 0;
    n3 = 0;
    for (int i = 1; i <= 20 && (n2 == 0 || n3 == 0); i++) begin
      @(posedge clk); #1;
      if (l2 && n2 == 0) n2 = i;
      if (l3 && n3 == 0) n3 = i;
    end
    chk("d2.lock_lat", n2, 7);
    chk("d3.lock_lat", n3, 8);

    repeat (10) @(posedge clk);
    #1;
    chk("d3.edge_cnt", int'(g3), 5);
    chk("d3.err_cnt", int'(e3), 0);
    chk("d3.state", int'(s3), 3);

    rst = 1'b1;
    @(posedge clk); #1;
    chk("d3rst.state", int'(s3), 0);
    chk("d3rst.locked", int'(l3), 0);
    chk("d3rst.err_pulse", int'(p3), 0);
    chk("d3rst.err_cnt", int'(e3), 0);
    chk("d3rst.edge_cnt", int'(g3), 0);
    chk("d3rst.fail", int'(f3), 0);
    chk("d2rst.state", int'(s2), 0);
    chk("d2rst.edge_cnt", int'(g2), 0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
